// File: rtl/rate_change_sequencer_if.sv
// Command channel of the rate-change sequencer: a rate index offered over valid/ready.
// The master drives the request; the sequencer (slave) answers with ready.
interface rate_change_sequencer_if #(
  parameter int RATE_WIDTH = 4
);
  logic [RATE_WIDTH-1:0] cmd_rate;
  logic                  cmd_valid;
  logic                  cmd_ready;

  modport master (output cmd_rate, output cmd_valid, input cmd_ready);
  modport slave  (input cmd_rate, input cmd_valid, output cmd_ready);
endinterface

// File: rtl/rate_change_sequencer.sv
// Sequences rate-change commands into the QPSK variable-rate datapath: waits for the stream
// to go quiet, reprograms rate_select behind a one-cycle datapath reset, then waits for ready.
module rate_change_sequencer #(
  parameter int RATE_WIDTH     = 4,
  parameter int MAX_RATE_IDX   = 12,
  parameter int DEFAULT_RATE   = 0,
  parameter int QUIET_CYCLES   = 8,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  rate_change_sequencer_if.slave cmd,
  input  logic                  dp_valid,
  input  logic                  dp_ready,
  output logic [RATE_WIDTH-1:0] rate_select,
  output logic                  dp_reset,
  output logic                  dp_hold,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [RATE_WIDTH-1:0] active_rate,
  output logic [CNT_WIDTH-1:0]  change_count
);

  typedef enum logic [2:0] {
    BOOT,
    IDLE,
    QUIET,
    RESET_DP,
    SETTLE
  } state_t;

  localparam logic [RATE_WIDTH-1:0] MAX_IDX      = RATE_WIDTH'(MAX_RATE_IDX);
  localparam logic [RATE_WIDTH-1:0] DEF_RATE     = RATE_WIDTH'(DEFAULT_RATE);
  localparam logic [CNT_WIDTH-1:0]  QUIET_LAST   = CNT_WIDTH'(QUIET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  SETTLE_LAST  = CNT_WIDTH'(SETTLE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE      = CNT_WIDTH'(1);

  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_QUIET   = 2'b10;
  localparam logic [1:0] ERR_READY   = 2'b11;

  state_t                state, state_nxt;
  logic [CNT_WIDTH-1:0]  quiet_cnt, quiet_cnt_nxt;
  logic [CNT_WIDTH-1:0]  settle_cnt, settle_cnt_nxt;
  logic [CNT_WIDTH-1:0]  timeout_cnt, timeout_cnt_nxt;
  logic [RATE_WIDTH-1:0] new_rate, new_rate_nxt;
  logic [RATE_WIDTH-1:0] rate_select_nxt, active_rate_nxt;
  logic                  dp_reset_nxt, dp_hold_nxt, busy_nxt, ready, ready_nxt;
  logic                  done_nxt, err_nxt;
  logic [1:0]            err_code_nxt;
  logic [CNT_WIDTH-1:0]  change_count_nxt;

  assign cmd.cmd_ready = ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= BOOT;
      quiet_cnt    <= '0;
      settle_cnt   <= '0;
      timeout_cnt  <= '0;
      new_rate     <= DEF_RATE;
      rate_select  <= DEF_RATE;
      active_rate  <= DEF_RATE;
      dp_reset     <= 1'b1;
      dp_hold      <= 1'b1;
      busy         <= 1'b1;
      ready        <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
      err_code     <= 2'b00;
      change_count <= '0;
    end else begin
      state        <= state_nxt;
      quiet_cnt    <= quiet_cnt_nxt;
      settle_cnt   <= settle_cnt_nxt;
      timeout_cnt  <= timeout_cnt_nxt;
      new_rate     <= new_rate_nxt;
      rate_select  <= rate_select_nxt;
      active_rate  <= active_rate_nxt;
      dp_reset     <= dp_reset_nxt;
      dp_hold      <= dp_hold_nxt;
      busy         <= busy_nxt;
      ready        <= ready_nxt;
      done         <= done_nxt;
      err          <= err_nxt;
      err_code     <= err_code_nxt;
      change_count <= change_count_nxt;
    end
  end

  always_comb begin
    state_nxt        = state;
    quiet_cnt_nxt    = quiet_cnt;
    settle_cnt_nxt   = settle_cnt;
    timeout_cnt_nxt  = timeout_cnt;
    new_rate_nxt     = new_rate;
    rate_select_nxt  = rate_select;
    active_rate_nxt  = active_rate;
    dp_reset_nxt     = 1'b0;
    dp_hold_nxt      = dp_hold;
    busy_nxt         = busy;
    ready_nxt        = ready;
    done_nxt         = 1'b0;
    err_nxt          = 1'b0;
    err_code_nxt     = err_code;
    change_count_nxt = change_count;

    case (state)
      BOOT: begin
        state_nxt   = IDLE;
        dp_hold_nxt = 1'b0;
        busy_nxt    = 1'b0;
        ready_nxt   = 1'b1;
      end

      IDLE: begin
        if (cmd.cmd_valid && ready) begin
          if (cmd.cmd_rate > MAX_IDX) begin
            err_nxt      = 1'b1;
            err_code_nxt = ERR_ILLEGAL;
          end else if (cmd.cmd_rate == active_rate) begin
            done_nxt = 1'b1;
          end else begin
            new_rate_nxt    = cmd.cmd_rate;
            state_nxt       = QUIET;
            ready_nxt       = 1'b0;
            busy_nxt        = 1'b1;
            dp_hold_nxt     = 1'b1;
            quiet_cnt_nxt   = '0;
            timeout_cnt_nxt = '0;
          end
        end
      end

      // A quiet run completing on the timeout edge still counts as quiet.
      QUIET: begin
        timeout_cnt_nxt = timeout_cnt + CNT_ONE;
        if (!dp_valid && quiet_cnt == QUIET_LAST) begin
          state_nxt       = RESET_DP;
          rate_select_nxt = new_rate;
          dp_reset_nxt    = 1'b1;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_nxt    = IDLE;
          err_nxt      = 1'b1;
          err_code_nxt = ERR_QUIET;
          dp_hold_nxt  = 1'b0;
          busy_nxt     = 1'b0;
          ready_nxt    = 1'b1;
        end else begin
          quiet_cnt_nxt = dp_valid ? '0 : quiet_cnt + CNT_ONE;
        end
      end

      RESET_DP: begin
        state_nxt       = SETTLE;
        settle_cnt_nxt  = '0;
        timeout_cnt_nxt = '0;
      end

      // The datapath is already running at the new rate, so even a timeout adopts it.
      SETTLE: begin
        timeout_cnt_nxt = timeout_cnt + CNT_ONE;
        if (settle_cnt != SETTLE_LAST) begin
          settle_cnt_nxt = settle_cnt + CNT_ONE;
        end
        if (settle_cnt == SETTLE_LAST && dp_ready) begin
          state_nxt        = IDLE;
          active_rate_nxt  = new_rate;
          done_nxt         = 1'b1;
          dp_hold_nxt      = 1'b0;
          busy_nxt         = 1'b0;
          ready_nxt        = 1'b1;
          change_count_nxt = (&change_count) ? change_count : change_count + CNT_ONE;
        end else if (timeout_cnt == TIMEOUT_LAST) begin
          state_nxt       = IDLE;
          active_rate_nxt = new_rate;
          err_nxt         = 1'b1;
          err_code_nxt    = ERR_READY;
          dp_hold_nxt     = 1'b0;
          busy_nxt        = 1'b0;
          ready_nxt       = 1'b1;
        end
      end

      default: begin
        state_nxt = BOOT;
      end
    endcase
  end

endmodule
